// File: rtl/siso_loop_ctrl_pkg.sv
// Shared definitions for the serial-in/serial-out chain sequencer.
package siso_loop_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Default word width and chain latency (4 storage stages + registered so).
    localparam int W_DEF   = 4;
    localparam int LAT_DEF = 5;

    // Mismatch counter width and its saturation value.
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/siso_loop_ctrl.sv
// Loopback sequencer for a serial shift chain: serializes a parallel word
// LSB-first with a shift enable, flushes the chain with zeros, recaptures the
// emerging bits and returns the recovered word with a mismatch flag.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid stays high with
// out_data/out_err stable until the edge where out_ready is seen.
module siso_loop_ctrl
    import siso_loop_ctrl_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             sr_si,
    output logic             sr_en,
    input  logic             so_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    // Counter spans SHIFT cycles 0 .. W+LAT-1.
    localparam int CW = ((W + LAT) > 1) ? $clog2(W + LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(W + LAT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  tx_reg;
    logic [W-1:0]  rx_reg;
    logic [CW-1:0] cnt;

    logic [W-1:0]  rx_final;
    logic [CW-1:0] cnt_nxt;
    logic          nxt_bit;
    logic          mismatch;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign fsm_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)      state_d = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST)   state_d = ST_OUT;
            ST_OUT:   if (out_ready)     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Capture view including the bit sampled on this edge, and the bit to
    // drive in the following SHIFT cycle (zero once the word is exhausted).
    always_comb begin
        rx_final = rx_reg;
        for (int i = 0; i < W; i++) begin
            if (cnt == CW'(i + LAT)) rx_final[i] = so_in;
        end
        cnt_nxt = cnt + 1'b1;
        nxt_bit = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (cnt_nxt == CW'(i)) nxt_bit = tx_reg[i];
        end
        mismatch = (rx_final != tx_reg);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_reg    <= '0;
            rx_reg    <= '0;
            cnt       <= '0;
            sr_en     <= 1'b0;
            sr_si     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        tx_reg <= in_data;
                        rx_reg <= '0;
                        cnt    <= '0;
                        sr_en  <= 1'b1;
                        sr_si  <= in_data[0];
                    end
                end
                ST_SHIFT: begin
                    rx_reg <= rx_final;
                    if (cnt == LAST) begin
                        sr_en     <= 1'b0;
                        sr_si     <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= rx_final;
                        out_err   <= mismatch;
                        if (mismatch && (err_cnt != ERR_MAX)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        cnt   <= cnt_nxt;
                        sr_si <= nxt_bit;
                    end
                end
                ST_OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
